// File: rtl/uart_tx_param_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
package uart_tx_param_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam logic ParEven  = 1'b0;
  localparam logic ParOdd   = 1'b1;
  localparam logic LineIdle = 1'b1;

  // Turns the XOR-reduction of the data word into the transmitted parity bit.
  function automatic logic parity_bit(logic xor_red, logic par_type);
    logic r_bit;
    case (par_type)
      ParEven: r_bit = xor_red;
      ParOdd:  r_bit = ~xor_red;
    endcase
    return r_bit;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Valid/ready word channel from the host data path into the UART transmitter.
interface uart_tx_param_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  data_ready;

  modport master (output p_data, output data_valid, input data_ready);
  modport slave  (input p_data, input data_valid, output data_ready);

endinterface

// File: rtl/uart_tx_param_fifo.sv
// Synchronous FIFO with wrapping pointers carrying an extra MSB to tell full from empty.
module uart_tx_param_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  localparam logic [AW:0] DepthVal = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_level   = r_wptr - r_rptr;
  assign o_full    = (o_level == DepthVal);
  assign o_empty   = (o_level == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter: FIFO-buffered words sent LSB-first with optional parity, 1 or 2 stop bits
// and a runtime bit period; frames run back-to-back while the FIFO holds data.
module uart_tx_param
  import uart_tx_param_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned PRESC_WIDTH = 16,
  localparam int unsigned LevelW     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  uart_tx_param_if.slave         s_bus,
  input  logic                   i_par_en,
  input  logic                   i_par_type,
  input  logic                   i_stop2,
  input  logic [PRESC_WIDTH-1:0] i_prescale,
  output logic                   o_tx_out,
  output logic                   o_busy,
  output logic [LevelW-1:0]      o_fifo_level
);

  localparam int unsigned BitW    = $clog2(DATA_WIDTH) + 1;
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

  tx_state_e              r_state, w_state_nxt;
  logic [PRESC_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [PRESC_WIDTH-1:0] r_presc_m1, w_presc_m1;
  logic [BitW-1:0]        r_bit, w_bit_nxt;
  logic [DATA_WIDTH-1:0]  r_shift, w_shift_nxt;
  logic                   r_par_en, r_par_bit, r_stop2;
  logic                   r_tx, w_tx_nxt;
  logic                   w_pop, w_tick, w_push, w_full, w_empty;
  logic [DATA_WIDTH-1:0]  w_fifo_rdata;

  assign w_presc_m1       = (i_prescale == '0) ? '0 : i_prescale - 1'b1;
  assign s_bus.data_ready = ~w_full | i_rst;
  assign w_push           = s_bus.data_valid & s_bus.data_ready;

  uart_tx_param_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata (s_bus.p_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_fifo_level)
  );

  assign w_tick = (r_cnt == r_presc_m1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_rdata;
          w_cnt_nxt   = '0;
          w_state_nxt = StStart;
        end
      end
      StStart: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = StData;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StData: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (r_bit == LastBit) begin
            w_bit_nxt   = '0;
            w_state_nxt = r_par_en ? StParity : StStop;
          end else begin
            w_bit_nxt   = r_bit + 1'b1;
            w_shift_nxt = r_shift >> 1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StParity: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = StStop;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StStop: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          // r_bit counts stop bits already sent so STOP2 stretches this state to 2P.
          if (r_stop2 && r_bit == '0) begin
            w_bit_nxt = 1'b1;
          end else if (!w_empty) begin
            w_bit_nxt   = '0;
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_rdata;
            w_state_nxt = StStart;
          end else begin
            w_bit_nxt   = '0;
            w_state_nxt = StIdle;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_tx_nxt = LineIdle;
    unique case (w_state_nxt)
      StStart:  w_tx_nxt = 1'b0;
      StData:   w_tx_nxt = w_shift_nxt[0];
      StParity: w_tx_nxt = r_par_bit;
      default:  w_tx_nxt = LineIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_tx       <= LineIdle;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_presc_m1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      // Frame configuration is captured with the word so mid-frame changes cannot disturb it.
      if (w_pop) begin
        r_par_en   <= i_par_en;
        r_par_bit  <= parity_bit(^w_fifo_rdata, i_par_type);
        r_stop2    <= i_stop2;
        r_presc_m1 <= w_presc_m1;
      end
    end
  end

  assign o_tx_out = r_tx;
  assign o_busy   = (r_state != StIdle);

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: table-driven single frames plus back-to-back and reset cases.
module tb_uart_tx_param;

  localparam int unsigned DW = 8;
  localparam int unsigned FD = 4;
  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          par_en, par_type, stop2;
  logic [PW-1:0] prescale;
  logic          tx_out, busy;
  logic [2:0]    level;

  uart_tx_param_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_param #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (FD),
    .PRESC_WIDTH (PW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .s_bus        (bus),
    .i_par_en     (par_en),
    .i_par_type   (par_type),
    .i_stop2      (stop2),
    .i_prescale   (prescale),
    .o_tx_out     (tx_out),
    .o_busy       (busy),
    .o_fifo_level (level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // bits[i] is the i-th line bit of the frame, start bit first.
  typedef struct {
    logic [7:0]  data;
    logic        par_en;
    logic        par_type;
    logic        stop2;
    logic [15:0] presc;
    int unsigned p_eff;
    int unsigned nbits;
    logic [11:0] bits;
    logic        mid_change;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int idx);
    int unsigned len;
    par_en         = v.par_en;
    par_type       = v.par_type;
    stop2          = v.stop2;
    prescale       = v.presc;
    bus.p_data     = v.data;
    bus.data_valid = 1'b1;
    check($sformatf("v%0d_ready", idx), bus.data_ready, 1);
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    check($sformatf("v%0d_lat_tx", idx), tx_out, 1);
    check($sformatf("v%0d_lat_busy", idx), busy, 0);
    check($sformatf("v%0d_lat_level", idx), level, 1);
    @(posedge clk); #1;
    check($sformatf("v%0d_pop_level", idx), level, 0);
    if (v.mid_change) begin
      prescale = 16'd9;
      par_en   = ~v.par_en;
      par_type = ~v.par_type;
      stop2    = ~v.stop2;
    end
    len = v.nbits * v.p_eff;
    for (int c = 0; c < int'(len); c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      check($sformatf("v%0d_c%0d_tx", idx, c), tx_out, v.bits[c / int'(v.p_eff)]);
      check($sformatf("v%0d_c%0d_busy", idx, c), busy, 1);
    end
    @(posedge clk); #1;
    check($sformatf("v%0d_end_busy", idx), busy, 0);
    check($sformatf("v%0d_end_tx", idx), tx_out, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] words [6];
    logic       exp_stream [60];
    logic       saw_full;
    int         max_level;
    int         busy_low;
    int         k;
    int         guard;
    logic       rdy;

    vecs[0] = '{data: 8'hA5, par_en: 0, par_type: 0, stop2: 0, presc: 16'd1, p_eff: 1,
                nbits: 10, bits: 12'h34A, mid_change: 0};
    vecs[1] = '{data: 8'h07, par_en: 1, par_type: 0, stop2: 1, presc: 16'd4, p_eff: 4,
                nbits: 12, bits: 12'hE0E, mid_change: 0};
    vecs[2] = '{data: 8'h00, par_en: 1, par_type: 1, stop2: 0, presc: 16'd2, p_eff: 2,
                nbits: 11, bits: 12'h600, mid_change: 0};
    vecs[3] = '{data: 8'hFF, par_en: 1, par_type: 1, stop2: 0, presc: 16'd1, p_eff: 1,
                nbits: 11, bits: 12'h7FE, mid_change: 0};
    vecs[4] = '{data: 8'h5A, par_en: 0, par_type: 0, stop2: 0, presc: 16'd0, p_eff: 1,
                nbits: 10, bits: 12'h2B4, mid_change: 0};
    vecs[5] = '{data: 8'h3C, par_en: 1, par_type: 0, stop2: 1, presc: 16'd3, p_eff: 3,
                nbits: 12, bits: 12'hC78, mid_change: 1};

    rst            = 1'b1;
    bus.data_valid = 1'b0;
    bus.p_data     = '0;
    par_en         = 1'b0;
    par_type       = 1'b0;
    stop2          = 1'b0;
    prescale       = 16'd1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx_out, 1);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_ready", bus.data_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_tx", tx_out, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", bus.data_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
      @(posedge clk); #1;
    end

    // Six words back-to-back, 8N1 at one bit per clock.
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int w = 0; w < 6; w++) begin
      exp_stream[w * 10] = 1'b0;
      for (int j = 0; j < 8; j++) exp_stream[w * 10 + 1 + j] = words[w][j];
      exp_stream[w * 10 + 9] = 1'b1;
    end
    par_en    = 1'b0;
    stop2     = 1'b0;
    prescale  = 16'd1;
    saw_full  = 1'b0;
    max_level = 0;
    busy_low  = 0;
    fork
      begin
        k     = 0;
        guard = 0;
        while (k < 6 && guard < 200) begin
          bus.p_data     = words[k];
          bus.data_valid = 1'b1;
          rdy            = bus.data_ready;
          if (!rdy) saw_full = 1'b1;
          @(posedge clk); #1;
          guard++;
          if (rdy) k++;
        end
        bus.data_valid = 1'b0;
        check("b2b_all_pushed", k, 6);
      end
      begin
        for (int g = 0; g < 30 && !busy; g++) begin
          @(posedge clk); #1;
        end
        check("b2b_start_busy", busy, 1);
        for (int c = 0; c < 60; c++) begin
          if (c > 0) begin
            @(posedge clk); #1;
          end
          if (int'(level) > max_level) max_level = int'(level);
          if (!busy) busy_low++;
          check($sformatf("b2b_c%0d_tx", c), tx_out, exp_stream[c]);
        end
        check("b2b_busy_gaps", busy_low, 0);
        @(posedge clk); #1;
        check("b2b_end_busy", busy, 0);
        check("b2b_end_level", level, 0);
        check("b2b_end_tx", tx_out, 1);
      end
    join
    check("b2b_saw_not_ready", saw_full, 1);
    check("b2b_max_level", max_level, 4);

    // Reset in the middle of data bit 3 with another word still buffered.
    @(posedge clk); #1;
    bus.p_data     = 8'hC3;
    bus.data_valid = 1'b1;
    @(posedge clk); #1;
    bus.p_data = 8'h3C;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    check("mid_start_tx", tx_out, 0);
    check("mid_level", level, 1);
    repeat (4) @(posedge clk);
    #1;
    check("mid_bit3_busy", busy, 1);
    check("mid_bit3_tx", tx_out, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_tx", tx_out, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_ready", bus.data_ready, 1);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_idle_tx", tx_out, 1);
    check("mid_idle_busy", busy, 0);
    run_vec(vecs[0], 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
